// File: rtl/ledger_datapath.sv
// ledger_datapath: N-player coin ledger with argument/funds/key checks and atomic commit.
// Optional RECV_OVERFLOW_CHECK_EN: reject transfers that would overflow the receiver balance.
module ledger_datapath #(
    parameter int N_PLAYERS = 4,
    parameter int W         = 8,
    parameter int ROUNDS    = 4,
    parameter int PW        = $clog2(N_PLAYERS)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       load_ledger,
    input  logic [N_PLAYERS*3*W-1:0]   memory_values,
    input  logic [16*W-1:0]            random_table,
    input  logic                       start,
    input  logic [PW-1:0]              sender,
    input  logic [PW-1:0]              receiver,
    input  logic [W-1:0]               amount,
    input  logic [W-1:0]               key,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 status,
    output logic [N_PLAYERS*3*W-1:0]   result_out,
    output logic [15:0]                tx_count
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam int SW = 3 * W;

    typedef enum logic [1:0] {IDLE, CHECK, HASH, REPORT} state_t;

    state_t state, state_next;

    logic [W-1:0]  priv_key [N_PLAYERS];
    logic [W-1:0]  pub_key  [N_PLAYERS];
    logic [W-1:0]  balance  [N_PLAYERS];

    logic [PW-1:0] tx_sender;
    logic [PW-1:0] tx_receiver;
    logic [W-1:0]  tx_amount;
    logic [W-1:0]  h;
    logic [W-1:0]  h_next;
    logic [RW-1:0] round;
    logic          arg_err;
    logic          funds_err;
    logic          last_round;
    logic          key_ok;
`ifdef RECV_OVERFLOW_CHECK_EN
    logic [W:0]    rx_sum;
`endif

    // Request validation and one table-hash round on the latched request
    always_comb begin
        arg_err = (tx_sender == tx_receiver)
               || (int'(tx_sender) >= N_PLAYERS)
               || (int'(tx_receiver) >= N_PLAYERS);
`ifdef RECV_OVERFLOW_CHECK_EN
        rx_sum  = {1'b0, balance[tx_receiver]} + {1'b0, tx_amount};
        arg_err = arg_err || rx_sum[W];
`endif
        funds_err  = tx_amount > balance[tx_sender];
        h_next     = {h[W-2:0], h[W-1]}
                   ^ random_table[int'(h[3:0]) * W +: W];
        last_round = (round == RW'(ROUNDS - 1));
        key_ok     = (h_next == pub_key[tx_sender]);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; load_ledger has priority over start in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!load_ledger && start) state_next = CHECK;
            CHECK:   state_next = (arg_err || funds_err) ? REPORT : HASH;
            HASH:    if (last_round) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == REPORT);

    // Ledger image, request latch, hash state, status and commit
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tx_sender   <= '0;
            tx_receiver <= '0;
            tx_amount   <= '0;
            h           <= '0;
            round       <= '0;
            status      <= 2'd0;
            tx_count    <= 16'd0;
            for (int p = 0; p < N_PLAYERS; p++) begin
                priv_key[p] <= '0;
                pub_key[p]  <= '0;
                balance[p]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_ledger) begin
                        for (int p = 0; p < N_PLAYERS; p++) begin
                            {priv_key[p], pub_key[p], balance[p]} <=
                                memory_values[(N_PLAYERS-1-p)*SW +: SW];
                        end
                    end else if (start) begin
                        tx_sender   <= sender;
                        tx_receiver <= receiver;
                        tx_amount   <= amount;
                        h           <= key;
                        round       <= '0;
                    end
                end
                CHECK: begin
                    if (arg_err)        status <= 2'd3;
                    else if (funds_err) status <= 2'd1;
                end
                HASH: begin
                    h     <= h_next;
                    round <= round + 1'b1;
                    if (last_round) begin
                        if (key_ok) begin
                            balance[tx_sender]   <= balance[tx_sender] - tx_amount;
                            balance[tx_receiver] <= balance[tx_receiver] + tx_amount;
                            tx_count             <= tx_count + 16'd1;
                            status               <= 2'd0;
                        end else begin
                            status <= 2'd2;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Repack the ledger for the output bus
    always_comb begin
        result_out = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            result_out[(N_PLAYERS-1-p)*SW +: SW] = {priv_key[p], pub_key[p], balance[p]};
        end
    end

endmodule

// File: tb/tb_ledger_datapath.sv
// tb_ledger_datapath: directed transfers against a per-cycle ledger model.
// Build with or without RECV_OVERFLOW_CHECK_EN; expectations follow the macro.
module tb_ledger_datapath;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int PW = 2;

    logic             clock = 1'b0;
    logic             resetn;
    logic             load_ledger;
    logic [N*3*W-1:0] memory_values;
    logic [16*W-1:0]  random_table;
    logic             start;
    logic [PW-1:0]    sender, receiver;
    logic [W-1:0]     amount, key;
    logic             busy, done;
    logic [1:0]       status;
    logic [N*3*W-1:0] result_out;
    logic [15:0]      tx_count;

    ledger_datapath #(.N_PLAYERS(N), .W(W), .ROUNDS(R)) dut (
        .clock(clock), .resetn(resetn), .load_ledger(load_ledger),
        .memory_values(memory_values), .random_table(random_table),
        .start(start), .sender(sender), .receiver(receiver),
        .amount(amount), .key(key), .busy(busy), .done(done),
        .status(status), .result_out(result_out), .tx_count(tx_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_priv [N];
    logic [7:0]  m_pub  [N];
    logic [7:0]  m_bal  [N];
    logic [15:0] m_tx;
    logic        exp_busy, exp_done;
    logic [1:0]  exp_status;
    bit          chk_en = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*3*W-1:0] model_image();
        logic [N*3*W-1:0] img;
        img = '0;
        for (int p = 0; p < N; p++)
            img[(N-1-p)*24 +: 24] = {m_priv[p], m_pub[p], m_bal[p]};
        return img;
    endfunction

    function automatic void model_load(input logic [N*3*W-1:0] img);
        for (int p = 0; p < N; p++) begin
            m_priv[p] = img[(N-1-p)*24 + 16 +: 8];
            m_pub[p]  = img[(N-1-p)*24 + 8 +: 8];
            m_bal[p]  = img[(N-1-p)*24 +: 8];
        end
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < N; p++) begin
            m_priv[p] = 8'h00;
            m_pub[p]  = 8'h00;
            m_bal[p]  = 8'h00;
        end
        m_tx       = 16'd0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_status = 2'd0;
    endfunction

    // Outcome of a request from the ledger rules (table is all zero here)
    function automatic logic [1:0] predict(input int s, input int r, input int amt, input int k);
        int hv;
        if (s == r || s >= N || r >= N) return 2'd3;
`ifdef RECV_OVERFLOW_CHECK_EN
        if (int'(m_bal[r]) + amt > 255) return 2'd3;
`endif
        if (amt > int'(m_bal[s])) return 2'd1;
        hv = k;
        for (int i = 0; i < R; i++) begin
            hv = ((hv << 1) | (hv >> 7)) & 255;
            hv = hv ^ int'(random_table[(hv & 15) * 8 +: 8]);
        end
        return (hv == int'(m_pub[s])) ? 2'd0 : 2'd2;
    endfunction

    // Single compare process: DUT vs model on every falling edge
    always @(negedge clock) begin
        if (chk_en) begin
            check("ledger", result_out, model_image());
            check("tx_count", tx_count, m_tx);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("status", status, exp_status);
        end
    end

    task automatic load(input logic [N*3*W-1:0] img, input bit with_start);
        memory_values = img;
        load_ledger   = 1'b1;
        if (with_start) begin
            start = 1'b1; sender = 2'd0; receiver = 2'd2;
            amount = 8'h14; key = 8'h81;
        end
        @(posedge clock); #1;
        load_ledger = 1'b0;
        start       = 1'b0;
        model_load(img);
    endtask

    task automatic do_tx(input int s, input int r, input int amt, input int k,
                         input int abort_at, input bit extra_start);
        logic [1:0] st;
        int lat;
        st  = predict(s, r, amt, k);
        lat = (st == 2'd1 || st == 2'd3) ? 2 : R + 2;
        sender = PW'(s); receiver = PW'(r);
        amount = W'(amt); key = W'(k);
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            exp_busy = 1'b1;
            exp_done = (c == lat);
            if (c == lat) begin
                if (st == 2'd0) begin
                    m_bal[s] = m_bal[s] - 8'(amt);
                    m_bal[r] = m_bal[r] + 8'(amt);
                    m_tx     = m_tx + 16'd1;
                end
                exp_status = st;
            end
            if (extra_start && c == 1) begin
                start = 1'b1; sender = 2'd2; receiver = 2'd3;
                amount = 8'h01; key = 8'h99;
            end
            if (c == abort_at) resetn = 1'b0;
            @(posedge clock); #1;
            start = 1'b0;
            if (c == abort_at) begin
                resetn = 1'b1;
                model_reset();
                return;
            end
        end
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [N*3*W-1:0] img_a;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        img_a = {24'h44_77_F0, 24'h33_99_0A, 24'h22_44_30, 24'h11_18_64};
        img_a = {24'h11_18_64, 24'h22_44_30, 24'h33_99_0A, 24'h44_77_F0};
        random_table  = '0;
        memory_values = '0;
        load_ledger   = 1'b0;
        start         = 1'b0;
        sender = '0; receiver = '0; amount = '0; key = '0;
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 2'd0);
        check("rst_result", result_out, 96'd0);
        check("rst_tx", tx_count, 16'd0);
        @(posedge clock); #1;
        chk_en = 1;

        load(img_a, 1'b0);
        do_tx(0, 2, 'h14, 'h81, 0, 1'b0);
        check("ok_status", status, 2'd0);
        check("ok_bal0", result_out[72 +: 8], 8'h50);
        check("ok_bal2", result_out[24 +: 8], 8'h1E);
        check("ok_tx", tx_count, 16'd1);

        do_tx(0, 2, 'h14, 'h82, 0, 1'b0);
        check("key_status", status, 2'd2);
        check("key_bal0", result_out[72 +: 8], 8'h50);
        check("key_tx", tx_count, 16'd1);

        load(img_a, 1'b0);
        do_tx(0, 2, 'h65, 'h81, 0, 1'b0);
        check("funds_status", status, 2'd1);
        do_tx(0, 2, 'h64, 'h81, 0, 1'b0);
        check("exact_status", status, 2'd0);
        check("exact_bal0", result_out[72 +: 8], 8'h00);

        do_tx(1, 1, 'h05, 'h44, 0, 1'b1);
        check("arg_status", status, 2'd3);
        idle(2);

        do_tx(1, 3, 'h20, 'h44, 0, 1'b0);
`ifdef RECV_OVERFLOW_CHECK_EN
        check("ovf_status", status, 2'd3);
        check("ovf_bal3", result_out[0 +: 8], 8'hF0);
`else
        check("ovf_status", status, 2'd0);
        check("ovf_bal3", result_out[0 +: 8], 8'h10);
`endif

        do_tx(3, 0, 0, 'h77, 0, 1'b0);
        check("zero_status", status, 2'd0);

        do_tx(2, 0, 1, 'h99, 3, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_result", result_out, 96'd0);
        check("abort_tx", tx_count, 16'd0);
        idle(8);

        load(img_a, 1'b1);
        check("ls_busy", busy, 1'b0);
        check("ls_bal0", result_out[72 +: 8], 8'h64);
        idle(3);
        do_tx(0, 2, 'h14, 'h81, 0, 1'b0);
        check("after_status", status, 2'd0);
        check("after_tx", tx_count, 16'd1);
        idle(2);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
